// File: rtl/serial_word_collector_if.sv
// rtl/serial_word_collector_if.sv - serial bit input / word output handshake bundle
interface serial_word_collector_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    logic                     bit_in;
    logic                     bit_valid;
    logic                     frame_start;
    logic                     word_ready;
    logic                     clear_ovf;
    logic [WIDTH-1:0]         word_out;
    logic                     word_valid;
    logic [$clog2(DEPTH):0]   level;
    logic [$clog2(WIDTH)-1:0] bit_pos;
    logic                     frame_err;
    logic                     overflow;

    modport master (
        output bit_in, bit_valid, frame_start, word_ready, clear_ovf,
        input  word_out, word_valid, level, bit_pos, frame_err, overflow
    );

    modport slave (
        input  bit_in, bit_valid, frame_start, word_ready, clear_ovf,
        output word_out, word_valid, level, bit_pos, frame_err, overflow
    );
endinterface

// File: rtl/serial_word_collector.sv
// rtl/serial_word_collector.sv - serial-to-word assembler with output FIFO
module serial_word_collector #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int LSB_FIRST = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    serial_word_collector_if.slave bus
);
    localparam int PW = $clog2(WIDTH);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] r_shift;
    logic [PW-1:0]    r_bit_pos;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic [WIDTH-1:0] r_word_out;
    logic             r_word_valid;
    logic             r_frame_err;
    logic             r_overflow;

    logic [PW-1:0]    w_idx;
    logic [WIDTH-1:0] w_new_word;
    logic [WIDTH-1:0] w_first_word;
    logic [AW-1:0]    w_rd_next;
    logic [LW-1:0]    w_level_nxt;
    logic             w_pop;
    logic             w_last_bit;
    logic             w_complete;
    logic             w_push;
    logic             w_drop;

    assign w_idx = (LSB_FIRST != 0) ? r_bit_pos : PW'(WIDTH - 1) - r_bit_pos;

    always_comb begin
        w_new_word = r_shift;
        for (int i = 0; i < WIDTH; i++) begin
            if (i == int'(w_idx)) w_new_word[i] = bus.bit_in;
        end
    end

    // First bit of a realigned word goes to the slot a fresh word would use.
    always_comb begin
        w_first_word = '0;
        if (LSB_FIRST != 0) w_first_word[0] = bus.bit_in;
        else                w_first_word[WIDTH-1] = bus.bit_in;
    end

    assign w_pop       = r_word_valid & bus.word_ready;
    assign w_last_bit  = (r_bit_pos == PW'(WIDTH - 1));
    assign w_complete  = bus.bit_valid & ~bus.frame_start & w_last_bit;
    assign w_push      = w_complete & ((r_level != LW'(DEPTH)) | w_pop);
    assign w_drop      = w_complete & ~w_push;
    assign w_rd_next   = r_rd_ptr + AW'(1);
    assign w_level_nxt = r_level + LW'(w_push) - LW'(w_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift      <= '0;
            r_bit_pos    <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_word_out   <= '0;
            r_word_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_frame_err <= bus.frame_start && (r_bit_pos != '0);

            if (bus.frame_start) begin
                r_shift   <= bus.bit_valid ? w_first_word : '0;
                r_bit_pos <= bus.bit_valid ? PW'(1) : '0;
            end else if (bus.bit_valid) begin
                r_shift   <= w_new_word;
                r_bit_pos <= w_last_bit ? '0 : r_bit_pos + PW'(1);
            end

            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= w_rd_next;
            r_level      <= w_level_nxt;
            r_word_valid <= (w_level_nxt != '0);

            // Head register tracks the next FIFO head; it holds when the FIFO drains.
            if (w_pop && (r_level > LW'(1))) begin
                r_word_out <= r_mem[w_rd_next];
            end else if (w_push && ((r_level == '0) || (w_pop && (r_level == LW'(1))))) begin
                r_word_out <= w_new_word;
            end

            if (w_drop)             r_overflow <= 1'b1;
            else if (bus.clear_ovf) r_overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && w_push) r_mem[r_wr_ptr] <= w_new_word;
    end

    assign bus.word_out   = r_word_out;
    assign bus.word_valid = r_word_valid;
    assign bus.level      = r_level;
    assign bus.bit_pos    = r_bit_pos;
    assign bus.frame_err  = r_frame_err;
    assign bus.overflow   = r_overflow;
endmodule

// File: doc/serial_word_collector.md
Name: serial_word_collector

Overview:
- Downstream neighbour of the 8-bit capture/counter/mux serializer stage.
- Consumes the serial bit stream that stage produces (one bit per qualified cycle) and reassembles it into WIDTH-bit words.
- Buffers completed words in a small FIFO and presents them on a valid/ready interface to the next consumer.
- Reports framing errors (aborted partial words) and FIFO overflow.

Parameters:
- WIDTH, 8, bits per word; legal values are 2 to 32.
- DEPTH, 4, FIFO entries; power of two, 2 to 16.
- LSB_FIRST, 1, 1 = first received bit lands in word bit 0; 0 = first received bit lands in bit WIDTH-1.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high; sampled on the rising edge of clk.
- bit_in  input  1  serial data bit.
- bit_valid  input  1  bit_in is qualified this cycle.
- frame_start  input  1  realign: the current cycle begins a new word.
- word_out  output  WIDTH  head-of-FIFO word.
- word_valid  output  1  FIFO non-empty.
- word_ready  input  1  consumer accepts word_out when word_valid is high.
- level  output  $clog2(DEPTH)+1  FIFO occupancy, 0 to DEPTH.
- bit_pos  output  $clog2(WIDTH)  number of bits held in the partial word.
- frame_err  output  1  one-cycle pulse: a partial word was discarded.
- overflow  output  1  sticky: a completed word was dropped.
- clear_ovf  input  1  clears overflow.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high, named reset.
- Reset: on a cycle with reset high, all of the following are zero on the next edge:
  - word_out, word_valid, level, bit_pos, frame_err, overflow;
  - shift register, FIFO pointers.
  - Reset overrides every other input. A partial word in progress is lost silently (no frame_err).
- Assembly:
  - On each cycle with bit_valid=1, the bit is written at position bit_pos (LSB_FIRST=1) or WIDTH-1-bit_pos (LSB_FIRST=0).
  - bit_pos then increments.
  - When bit_valid=1 and bit_pos==WIDTH-1, the word is complete and bit_pos wraps to 0.
- bit_valid=0: no change to the shift register or bit_pos.
- frame_start=1:
  - If bit_pos!=0, the partial word is discarded and frame_err pulses high for exactly the next cycle.
  - If bit_valid is also 1, that bit becomes bit 0 of the new word and bit_pos becomes 1; otherwise bit_pos becomes 0.
  - If bit_pos==0, there is no frame_err.
  - With WIDTH-1 bits pending, a simultaneous frame_start and bit_valid is an abort, not a completion.
- FIFO push: a completed word is pushed at the completing edge.
  - word_valid and word_out reflect it on the next cycle (latency: 1 cycle after the last bit's edge).
- FIFO pop: when word_valid && word_ready at an edge, the head is removed; word_out shows the next entry, or holds its value when the FIFO becomes empty.
- word_ready while word_valid=0: ignored.
- Full FIFO (level==DEPTH) with a completing word:
  - If a pop occurs in the same cycle, the push is accepted and level stays DEPTH.
  - Otherwise the word is dropped, level is unchanged and overflow is set.
- Empty FIFO with a completing word: word_valid rises next cycle (no fall-through in the same cycle).
- Simultaneous push and pop at any non-full level: level is unchanged and order is preserved.
- overflow stays set until clear_ovf=1 or reset. If clear_ovf and a new drop occur in the same cycle, overflow stays set (set wins).
- Pointers wrap modulo DEPTH. level is computed from push/pop events, never from pointer difference alone.
- Consumer stability: word_out and word_valid are registered; word_out is stable while word_valid=1 and word_ready=0.

Test Plan:
- Basic LSB-first: reset, then 8 bit_valid cycles with bits 1,0,1,1,0,0,1,0 → word_out=8'h4D, word_valid=1 one cycle after the 8th bit; level=1; bit_pos back to 0.
- MSB-first (LSB_FIRST=0): same bit sequence → word_out=8'hB2.
- Gaps and realign: send 3 bits, idle 5 cycles with bit_valid=0, then frame_start+bit_valid → frame_err pulses once; the next word holds only the new bits; bit_pos=1 after that cycle.
- Overflow: word_ready=0, push 5 words (DEPTH=4) → level=4; 5th word dropped; overflow=1. Drain 4 words in order with no loss. Pulse clear_ovf → overflow=0.
- Full plus simultaneous pop: with level=4 and word_ready=1, complete a word → accepted; overflow stays 0; level=4; output order intact.
- Reset mid-word: after 5 bits and 2 queued words, assert reset for one cycle → word_valid=0, level=0, bit_pos=0, frame_err=0. The next 8 bits form a clean word.
